pmul_sched: RTL

Sequencer for Ed25519 scalar multiplication using constant-time, MSB-first double-and-add. It latches a scalar and drives the point-arithmetic unit with one double per scalar bit, always followed by one add. It also controls the X/Y/Z/T accumulator register file: clearing it to the neutral point and gating its write enables. A 0 bit still executes the add, but the write is suppressed, so run time does not depend on the scalar.

---
 rtl/ecc_pkg.sv | 14 +
 rtl/pmul_sched.sv | 78 +++++++
 2 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared types and constants for the Ed25519 scalar-multiplication sequencer.
package ecc_pkg;
  localparam int SCALAR_W = 255;
  localparam int FE_W = 255;
  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;
  localparam logic [FE_W-1:0] NEUTRAL_X = '0;
  localparam logic [FE_W-1:0] NEUTRAL_Y = FE_W'(1);
  localparam logic [FE_W-1:0] NEUTRAL_Z = FE_W'(1);
  localparam logic [FE_W-1:0] NEUTRAL_T = '0;
  typedef enum logic [2:0] {
    IDLE, CLR, DBL_ISSUE, DBL_WAIT, ADD_ISSUE, ADD_WAIT, DONE
  } pmul_state_t;
endpackage

// File: rtl/pmul_sched.sv
// pmul_sched: constant-time MSB-first double-and-add sequencer driving the point unit and accumulator enables.
module pmul_sched
  import ecc_pkg::*;
#(
  parameter int NBITS = SCALAR_W,
  parameter int CNT_W = $clog2(NBITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] k,
  output logic             pu_start,
  output logic             pu_op,
  input  logic             pu_done,
  output logic             acc_clr,
  output logic             acc_we,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_idx
);
  pmul_state_t state_q, state_d;
  logic [NBITS-1:0] ks_q, ks_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic pu_start_q, pu_start_d, pu_op_q, pu_op_d, acc_clr_q, acc_clr_d;
  logic busy_q, busy_d, done_q, done_d;
  logic accept, last, step;
  always_comb begin
    accept = state_q == IDLE && start;
    last = bit_idx_q == '0;
    step = state_q == ADD_WAIT && pu_done && !last;
    case (state_q)
      IDLE:      state_d = start ? CLR : IDLE;
      CLR:       state_d = DBL_ISSUE;
      DBL_ISSUE: state_d = DBL_WAIT;
      DBL_WAIT:  state_d = pu_done ? ADD_ISSUE : DBL_WAIT;
      ADD_ISSUE: state_d = ADD_WAIT;
      ADD_WAIT:  state_d = !pu_done ? ADD_WAIT : last ? DONE : DBL_ISSUE;
      default:   state_d = IDLE;
    endcase
    ks_d = accept ? k : step ? ks_q << 1 : ks_q;
    bit_idx_d = accept ? CNT_W'(NBITS - 1) : step ? bit_idx_q - 1'b1 : bit_idx_q;
    // Outputs are registered from the next state so they line up with the state they describe.
    pu_start_d = state_d == DBL_ISSUE || state_d == ADD_ISSUE;
    pu_op_d = state_d == DBL_ISSUE ? OP_DBL : state_d == ADD_ISSUE ? OP_ADD : pu_op_q;
    acc_clr_d = state_d == CLR;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    // The add always runs; a 0 scalar bit only suppresses its write.
    acc_we = pu_done && (state_q == DBL_WAIT || (state_q == ADD_WAIT && ks_q[NBITS-1]));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ks_q <= '0;
      bit_idx_q <= '0;
      pu_start_q <= 1'b0;
      pu_op_q <= 1'b0;
      acc_clr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ks_q <= ks_d;
      bit_idx_q <= bit_idx_d;
      pu_start_q <= pu_start_d;
      pu_op_q <= pu_op_d;
      acc_clr_q <= acc_clr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign pu_start = pu_start_q;
  assign pu_op = pu_op_q;
  assign acc_clr = acc_clr_q;
  assign busy = busy_q;
  assign done = done_q;
  assign bit_idx = bit_idx_q;
endmodule
